// File: rtl/qspi_ram_sampled.sv
// SPI/QSPI RAM peripheral that oversamples the SPI pins in the system clock domain.
// Supports read (03h), write (02h), fast read (0Bh), quad read (6Bh), quad write (32h) and read ID (9Fh).
`timescale 1ns/1ps
module qspi_ram_sampled #(
  parameter int         ADDR_BITS  = 6,
  parameter int         QUAD_DUMMY = 2,
  parameter logic [7:0] ID_BYTE    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_clk,
  input  logic                 spi_select,
  input  logic [3:0]           spi_d_in,
  output logic [3:0]           spi_d_out,
  output logic [3:0]           spi_d_oe,
  input  logic [ADDR_BITS-1:0] debug_addr,
  output logic [7:0]           debug_data,
  output logic                 busy
);
  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [4:0] QUAD_LAST = 5'(QUAD_DUMMY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sck_s;
  logic [1:0]           r_sel_s;
  logic [3:0]           r_din_m;
  logic [3:0]           r_din_s;
  logic                 r_sck_d;
  logic                 r_sel_d;
  logic [7:0]           r_cmd;
  logic [6:0]           r_shift;
  logic [7:0]           r_tx;
  logic [4:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_quad;
  logic                 r_id;
  logic                 r_fetch;
  logic [3:0]           r_out;
  logic [3:0]           r_oe;
  logic [7:0]           r_mem [DEPTH];

  logic       w_sck;
  logic       w_sel;
  logic       w_rise;
  logic       w_fall;
  logic       w_sel_fall;
  logic       w_d0;
  logic [7:0] w_cmd;
  logic [7:0] w_wbyte;
  logic [4:0] w_byte_last;
  logic       w_we;
  logic [4:0] w_dummy_last;
  logic [7:0] w_ram_rd;

  assign w_sck        = r_sck_s[1];
  assign w_sel        = r_sel_s[1];
  assign w_rise       = w_sck & ~r_sck_d;
  assign w_fall       = ~w_sck & r_sck_d;
  assign w_sel_fall   = r_sel_d & ~w_sel;
  assign w_d0         = r_din_s[0];
  assign w_cmd        = {r_shift, w_d0};
  assign w_wbyte      = r_quad ? {r_shift[3:0], r_din_s} : {r_shift, w_d0};
  assign w_byte_last  = r_quad ? 5'd1 : 5'd7;
  assign w_dummy_last = (r_cmd == 8'h0B) ? 5'd7 : QUAD_LAST;
  assign w_ram_rd     = r_mem[r_addr];
  // A commit needs the whole byte and a still-selected bus; partial bytes never reach RAM.
  assign w_we = (r_state == S_WRITE) && !w_sel && w_rise && (r_cnt == w_byte_last);

  assign spi_d_out = r_out;
  assign spi_d_oe  = r_oe;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s <= '0;
      r_sel_s <= '0;
      r_din_m <= '0;
      r_din_s <= '0;
      r_sck_d <= 1'b0;
      r_sel_d <= 1'b0;
    end else begin
      r_sck_s <= {r_sck_s[0], spi_clk};
      r_sel_s <= {r_sel_s[0], spi_select};
      r_din_m <= spi_d_in;
      r_din_s <= r_din_m;
      r_sck_d <= w_sck;
      r_sel_d <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cmd   <= '0;
      r_shift <= '0;
      r_tx    <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_quad  <= 1'b0;
      r_id    <= 1'b0;
      r_fetch <= 1'b0;
      r_out   <= '0;
      r_oe    <= '0;
    end else if (w_sel) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fetch <= 1'b0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_fetch <= 1'b0;
      case (r_state)
        S_IDLE: if (w_sel_fall) begin
          r_state <= S_CMD;
          r_cnt   <= '0;
        end
        S_CMD: if (w_rise) begin
          r_shift <= w_cmd[6:0];
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd7) begin
            r_cnt  <= '0;
            r_cmd  <= w_cmd;
            r_quad <= (w_cmd == 8'h6B) || (w_cmd == 8'h32);
            r_id   <= (w_cmd == 8'h9F);
            case (w_cmd)
              8'h03, 8'h02, 8'h0B, 8'h6B, 8'h32: r_state <= S_ADDR;
              8'h9F: begin
                r_state <= S_READ;
                r_fetch <= 1'b1;
              end
              default: r_state <= S_IGNORE;
            endcase
          end
        end
        S_ADDR: if (w_rise) begin
          // Only the low ADDR_BITS of the 24-bit address survive the shift.
          r_addr <= {r_addr[ADDR_BITS-2:0], w_d0};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            r_cnt <= '0;
            case (r_cmd)
              8'h03: begin
                r_state <= S_READ;
                r_fetch <= 1'b1;
              end
              8'h02, 8'h32: r_state <= S_WRITE;
              default:      r_state <= S_DUMMY;
            endcase
          end
        end
        S_DUMMY: if (w_rise) begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == w_dummy_last) begin
            r_cnt   <= '0;
            r_state <= S_READ;
            r_fetch <= 1'b1;
          end
        end
        S_READ: begin
          if (r_fetch) r_tx <= r_id ? ID_BYTE : w_ram_rd;
          if (w_fall) begin
            if (r_quad) begin
              r_out <= r_tx[7:4];
              r_oe  <= 4'b1111;
              r_tx  <= {r_tx[3:0], 4'h0};
            end else begin
              r_out <= {2'b00, r_tx[7], 1'b0};
              r_oe  <= 4'b0010;
              r_tx  <= {r_tx[6:0], 1'b0};
            end
            if (r_cnt == w_byte_last) begin
              r_cnt   <= '0;
              r_fetch <= 1'b1;
              if (!r_id) r_addr <= r_addr + ADDR_BITS'(1);
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        S_WRITE: if (w_rise) begin
          r_shift <= w_wbyte[6:0];
          if (r_cnt == w_byte_last) begin
            r_cnt  <= '0;
            r_addr <= r_addr + ADDR_BITS'(1);
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= w_wbyte;
  end

  // Read-before-write: a same-cycle commit shows up on debug_data one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) debug_data <= '0;
    else        debug_data <= r_mem[debug_addr];
  end
endmodule

// File: tb/tb_qspi_ram_sampled.sv
// Bench for qspi_ram_sampled: directed scenarios plus random transactions
// checked against a byte-array model of the RAM and an expected-byte queue.
`timescale 1ns/1ps
module tb_qspi_ram_sampled;
  localparam int         AB         = 6;
  localparam int         DEPTH      = 1 << AB;
  localparam int         QUAD_DUMMY = 2;
  localparam logic [7:0] ID         = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_select = 1'b1;
  logic [3:0]    spi_d_in = 4'h0;
  logic [3:0]    spi_d_out;
  logic [3:0]    spi_d_oe;
  logic [AB-1:0] debug_addr = '0;
  logic [7:0]    debug_data;
  logic          busy;

  qspi_ram_sampled #(.ADDR_BITS(AB), .QUAD_DUMMY(QUAD_DUMMY), .ID_BYTE(ID)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_clk    (spi_clk),
    .spi_select (spi_select),
    .spi_d_in   (spi_d_in),
    .spi_d_out  (spi_d_out),
    .spi_d_oe   (spi_d_oe),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  logic [3:0] pre_out_acc;
  logic [3:0] pre_oe_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: SCK changes on negedge clk, half period = 4 clk
  task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    spi_d_in = din;
    repeat (4) @(negedge clk);
    dout = spi_d_out;
    oe   = spi_d_oe;
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic pre_cycle(input logic [3:0] din);
    logic [3:0] o, e;
    sck_cycle(din, o, e);
    pre_out_acc |= o;
    pre_oe_acc  |= e;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pre_cycle({3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) pre_cycle({3'b000, a[i]});
  endtask

  task automatic begin_txn(input logic [7:0] cmd);
    pre_out_acc = '0;
    pre_oe_acc  = '0;
    spi_select  = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(cmd);
  endtask

  task automatic end_txn();
    repeat (2) @(negedge clk);
    spi_select = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_drop", 32'(busy), 32'd0);
    chk("idle_pins", 32'({spi_d_out, spi_d_oe}), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic write_txn(input logic quad, input logic [23:0] a);
    logic [7:0] b;
    int n;
    n = wr_q.size();
    begin_txn(quad ? 8'h32 : 8'h02);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      b = wr_q[i];
      if (quad) begin
        pre_cycle(b[7:4]);
        pre_cycle(b[3:0]);
      end else begin
        send_byte(b);
      end
      exp_mem[(int'(a[AB-1:0]) + i) % DEPTH] = b;
    end
    chk("wr_quiet", 32'({pre_out_acc, pre_oe_acc}), 32'd0);
    end_txn();
    wr_q.delete();
  endtask

  task automatic read_txn(input logic [7:0] cmd, input logic [23:0] a, input int n);
    logic [3:0] o, e, oe_or, oe_and, junk, eexp;
    logic [7:0] got, exp;
    logic       q;
    q    = (cmd == 8'h6B);
    eexp = q ? 4'b1111 : 4'b0010;
    for (int i = 0; i < n; i++)
      exp_q.push_back((cmd == 8'h9F) ? ID : exp_mem[(int'(a[AB-1:0]) + i) % DEPTH]);
    begin_txn(cmd);
    if (cmd != 8'h9F) send_addr(a);
    if (cmd == 8'h0B) repeat (8) pre_cycle(4'h0);
    if (cmd == 8'h6B) repeat (QUAD_DUMMY) pre_cycle(4'h0);
    chk("pre_data_quiet", 32'({pre_out_acc, pre_oe_acc}), 32'd0);
    for (int i = 0; i < n; i++) begin
      got = '0; oe_or = '0; oe_and = 4'hF; junk = '0;
      for (int k = 0; k < (q ? 2 : 8); k++) begin
        sck_cycle(4'h0, o, e);
        if (q) got = {got[3:0], o};
        else begin
          got  = {got[6:0], o[1]};
          junk |= o & 4'b1101;
        end
        oe_or  |= e;
        oe_and &= e;
      end
      exp = exp_q.pop_front();
      chk("rd_byte", 32'(got), 32'(exp));
      chk("rd_oe", 32'({junk, oe_or, oe_and}), 32'({4'h0, eexp, eexp}));
    end
    end_txn();
  endtask

  task automatic dbg_chk(input int a);
    debug_addr = AB'(a);
    @(negedge clk);
    @(negedge clk);
    chk("dbg_read", 32'(debug_data), 32'(exp_mem[a]));
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) dbg_chk(a);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  o, e;
    logic [7:0]  old;
    logic [23:0] ra;
    int          kind, n;

    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({spi_d_out, spi_d_oe, debug_data, busy}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_idle", 32'(busy), 32'd0);

    // preload every location so the model is fully known
    for (int i = 0; i < DEPTH; i++) wr_q.push_back(8'($urandom_range(0, 255)));
    write_txn(1'b0, 24'h000000);
    sweep();

    // write then read
    wr_q.push_back(8'h3C); wr_q.push_back(8'hC3);
    write_txn(1'b0, 24'h000005);
    read_txn(8'h03, 24'h000005, 2);
    dbg_chk(5);
    dbg_chk(6);

    // quad write with wrap, quad read back
    wr_q.push_back(8'h12); wr_q.push_back(8'h34);
    write_txn(1'b1, 24'h00003F);
    dbg_chk(63);
    dbg_chk(0);
    read_txn(8'h6B, 24'h00003F, 2);

    // partial write abort
    wr_q.push_back(8'h77);
    write_txn(1'b0, 24'h000010);
    begin_txn(8'h02);
    send_addr(24'h000010);
    for (int i = 0; i < 5; i++) pre_cycle({3'b000, 1'(i % 2)});
    spi_select = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    dbg_chk(16);
    read_txn(8'h03, 24'h000010, 1);

    // fast read and ID
    read_txn(8'h0B, 24'h000005, 1);
    read_txn(8'h9F, 24'h000000, 3);

    // bad command: ignored until deselect
    begin_txn(8'h55);
    for (int i = 0; i < 32; i++) pre_cycle({3'b000, 1'(i % 2)});
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_quiet", 32'({pre_out_acc, pre_oe_acc}), 32'd0);
    end_txn();
    sweep();

    // debug read colliding with a commit to the same address
    debug_addr = AB'(5);
    old = exp_mem[5];
    begin_txn(8'h02);
    send_addr(24'h000005);
    for (int i = 7; i >= 1; i--) pre_cycle({3'b000, 1'(8'h99 >> i)});
    spi_d_in = 4'b0001;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (3) @(negedge clk);
    chk("dbg_collide_old", 32'(debug_data), 32'(old));
    @(negedge clk);
    chk("dbg_collide_new", 32'(debug_data), 32'h99);
    exp_mem[5] = 8'h99;
    spi_clk = 1'b0;
    end_txn();

    // random traffic
    for (int t = 0; t < 16; t++) begin
      kind = int'($urandom_range(0, 5));
      n    = int'($urandom_range(1, 4));
      ra   = 24'($urandom);
      case (kind)
        0, 1: begin
          for (int i = 0; i < n; i++) wr_q.push_back(8'($urandom_range(0, 255)));
          write_txn(kind == 1, ra);
        end
        2:       read_txn(8'h03, ra, n);
        3:       read_txn(8'h0B, ra, n);
        4:       read_txn(8'h6B, ra, n);
        default: read_txn(8'h9F, ra, n);
      endcase
    end
    sweep();

    // async reset in the middle of a quad read
    debug_addr = AB'(5);
    begin_txn(8'h6B);
    send_addr(24'h000000);
    repeat (QUAD_DUMMY) pre_cycle(4'h0);
    sck_cycle(4'h0, o, e);
    repeat (2) @(negedge clk);
    chk("rst_pre_state", 32'({spi_d_oe, busy, debug_data}), 32'({4'hF, 1'b1, 8'h99}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({spi_d_out, spi_d_oe, debug_data, busy}), 32'd0);
    spi_select = 1'b1;
    spi_clk    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
